// File: rtl/alu_cmd_parser_pkg.sv
// Shared opcodes, header length and parser state encoding for the UART ALU command path.
package alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_MUL  = 8'h11;
    localparam logic [7:0] OP_DIV  = 8'h12;

    localparam logic [15:0] HDR_LEN = 16'd4;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_HDR,
        ST_PAYLOAD,
        ST_DRAIN
    } parse_state_e;

    function automatic logic is_arith(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_cmd_parser_if.sv
// Byte stream in, header / operand / echo streams and error pulse out of the command parser.
interface alu_cmd_parser_if #(
    parameter int DATA_WIDTH_P    = 8,
    parameter int OPERAND_WIDTH_P = 32
);
    logic [DATA_WIDTH_P-1:0]    s_axis_tdata;
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic                       hdr_valid_o;
    logic                       hdr_ready_i;
    logic [7:0]                 opcode_o;
    logic [15:0]                len_o;
    logic [OPERAND_WIDTH_P-1:0] op_tdata_o;
    logic                       op_tvalid_o;
    logic                       op_tready_i;
    logic                       op_tlast_o;
    logic [DATA_WIDTH_P-1:0]    echo_tdata_o;
    logic                       echo_tvalid_o;
    logic                       echo_tready_i;
    logic                       err_o;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, hdr_ready_i, op_tready_i, echo_tready_i,
        output s_axis_tready, hdr_valid_o, opcode_o, len_o, op_tdata_o, op_tvalid_o,
               op_tlast_o, echo_tdata_o, echo_tvalid_o, err_o
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, hdr_ready_i, op_tready_i, echo_tready_i,
        input  s_axis_tready, hdr_valid_o, opcode_o, len_o, op_tdata_o, op_tvalid_o,
               op_tlast_o, echo_tdata_o, echo_tvalid_o, err_o
    );
endinterface

// File: rtl/alu_cmd_parser_byte_to_word.sv
// LSB-first byte accumulator with a registered valid/ready word output.
// Word valid 1 cycle after its last byte; in_rdy drops while a finished word is stalled.
module byte_to_word #(
    parameter int DATA_WIDTH_P    = 8,
    parameter int OPERAND_WIDTH_P = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH_P-1:0]    in_dat,
    input  logic                       in_vld,
    input  logic                       in_last,
    output logic                       in_rdy,
    output logic [OPERAND_WIDTH_P-1:0] out_dat,
    output logic                       out_vld,
    output logic                       out_last,
    input  logic                       out_rdy
);
    localparam int N     = OPERAND_WIDTH_P / DATA_WIDTH_P;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0]                        idx_q;
    logic [OPERAND_WIDTH_P-DATA_WIDTH_P-1:0] shift_q;
    logic [OPERAND_WIDTH_P-1:0]              word_w;

    // Newest byte enters at the top, so the first byte ends up in the LSBs.
    assign word_w = {in_dat, shift_q};
    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            shift_q  <= '0;
            out_dat  <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
            if (in_vld && in_rdy) begin
                shift_q <= word_w[OPERAND_WIDTH_P-1:DATA_WIDTH_P];
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_q    <= '0;
                    out_dat  <= word_w;
                    out_vld  <= 1'b1;
                    out_last <= in_last;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_cmd_parser.sv
// Parses opcode/rsvd/len16 headers and splits payload into operand words or echo bytes.
// Outputs registered, 1 cycle after the triggering byte; s_axis_tready follows the active output.
module alu_cmd_parser
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH_P    = 8,
    parameter int OPERAND_WIDTH_P = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_cmd_parser_if.slave bus
);
    localparam logic [15:0] BYTES_PER_WORD = 16'(OPERAND_WIDTH_P / DATA_WIDTH_P);

    parse_state_e state_q;
    logic         run_q;
    logic [7:0]   opcode_q;
    logic [7:0]   len_lo_q;
    logic [15:0]  len_q;
    logic [15:0]  cnt_q;
    logic         hdr_vld_q;
    logic         err_q;
    logic [DATA_WIDTH_P-1:0] echo_dat_q;
    logic         echo_vld_q;

    logic         tready_w;
    logic         byte_acc;
    logic         is_echo;
    logic         w_in_vld;
    logic         w_in_rdy;
    logic [15:0]  len_w;
    logic [15:0]  pay_len_w;
    logic         known_w;
    logic         arith_w;
    logic         arith_bad_w;

    assign byte_acc    = bus.s_axis_tvalid && tready_w;
    assign is_echo     = (opcode_q == OP_ECHO);
    assign len_w       = {bus.s_axis_tdata[7:0], len_lo_q};
    assign pay_len_w   = len_w - HDR_LEN;
    assign arith_w     = is_arith(opcode_q);
    assign known_w     = arith_w || is_echo;
    assign arith_bad_w = (pay_len_w == 16'd0) || ((pay_len_w % BYTES_PER_WORD) != 16'd0);
    assign w_in_vld    = byte_acc && (state_q == ST_PAYLOAD) && !is_echo;

    // run_q keeps tready low in the first cycle out of reset.
    always_comb begin
        tready_w = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_HDR:     tready_w = 1'b0;
                ST_PAYLOAD: tready_w = is_echo ? (!echo_vld_q || bus.echo_tready_i) : w_in_rdy;
                default:    tready_w = 1'b1;
            endcase
        end
    end

    assign bus.s_axis_tready = tready_w;
    assign bus.hdr_valid_o   = hdr_vld_q;
    assign bus.opcode_o      = opcode_q;
    assign bus.len_o         = len_q;
    assign bus.echo_tdata_o  = echo_dat_q;
    assign bus.echo_tvalid_o = echo_vld_q;
    assign bus.err_o         = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OPCODE;
            run_q      <= 1'b0;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            hdr_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            echo_dat_q <= '0;
            echo_vld_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            err_q <= 1'b0;
            if (echo_vld_q && bus.echo_tready_i) begin
                echo_vld_q <= 1'b0;
            end
            case (state_q)
                ST_OPCODE: if (byte_acc) begin
                    opcode_q <= bus.s_axis_tdata[7:0];
                    state_q  <= ST_RSVD;
                end
                ST_RSVD: if (byte_acc) begin
                    state_q <= ST_LEN_LO;
                end
                ST_LEN_LO: if (byte_acc) begin
                    len_lo_q <= bus.s_axis_tdata[7:0];
                    state_q  <= ST_LEN_HI;
                end
                ST_LEN_HI: if (byte_acc) begin
                    len_q <= len_w;
                    cnt_q <= pay_len_w;
                    if (len_w < HDR_LEN) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_OPCODE;
                    end else if (!known_w || (arith_w && arith_bad_w)) begin
                        err_q   <= 1'b1;
                        state_q <= (pay_len_w == 16'd0) ? ST_OPCODE : ST_DRAIN;
                    end else begin
                        hdr_vld_q <= 1'b1;
                        state_q   <= ST_HDR;
                    end
                end
                ST_HDR: if (bus.hdr_ready_i) begin
                    hdr_vld_q <= 1'b0;
                    state_q   <= (len_q == HDR_LEN) ? ST_OPCODE : ST_PAYLOAD;
                end
                ST_PAYLOAD: if (byte_acc) begin
                    cnt_q <= cnt_q - 16'd1;
                    if (is_echo) begin
                        echo_dat_q <= bus.s_axis_tdata;
                        echo_vld_q <= 1'b1;
                    end
                    if (cnt_q == 16'd1) begin
                        state_q <= ST_OPCODE;
                    end
                end
                ST_DRAIN: if (byte_acc) begin
                    cnt_q <= cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_q <= ST_OPCODE;
                    end
                end
                default: state_q <= ST_OPCODE;
            endcase
        end
    end

    byte_to_word #(
        .DATA_WIDTH_P    (DATA_WIDTH_P),
        .OPERAND_WIDTH_P (OPERAND_WIDTH_P)
    ) u_b2w (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_dat   (bus.s_axis_tdata),
        .in_vld   (w_in_vld),
        .in_last  (cnt_q == 16'd1),
        .in_rdy   (w_in_rdy),
        .out_dat  (bus.op_tdata_o),
        .out_vld  (bus.op_tvalid_o),
        .out_last (bus.op_tlast_o),
        .out_rdy  (bus.op_tready_i)
    );

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Directed packets with a queue scoreboard; monitors compare every header, operand, echo byte and error pulse.
module tb_alu_cmd_parser;
    import alu_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   err_pending;

    logic [23:0] hdr_q[$];
    logic [32:0] op_q[$];
    logic [7:0]  echo_q[$];
    byte_q_t     pkt;

    alu_cmd_parser_if #(.DATA_WIDTH_P(8), .OPERAND_WIDTH_P(32)) bus ();

    alu_cmd_parser #(.DATA_WIDTH_P(8), .OPERAND_WIDTH_P(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none/other", name);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        bus.s_axis_tdata  = b;
        bus.s_axis_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.s_axis_tready && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!bus.s_axis_tready) fail_now("send_timeout");
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input byte_q_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hdr_valid"},  40'(bus.hdr_valid_o),   40'd0);
        chk({tag, "_op_tvalid"},  40'(bus.op_tvalid_o),   40'd0);
        chk({tag, "_echo_tvalid"},40'(bus.echo_tvalid_o), 40'd0);
        chk({tag, "_err"},        40'(bus.err_o),         40'd0);
        chk({tag, "_tready"},     40'(bus.s_axis_tready), 40'd0);
        chk({tag, "_op_tdata"},   40'(bus.op_tdata_o),    40'd0);
        chk({tag, "_op_tlast"},   40'(bus.op_tlast_o),    40'd0);
        chk({tag, "_echo_tdata"}, 40'(bus.echo_tdata_o),  40'd0);
        chk({tag, "_opcode"},     40'(bus.opcode_o),      40'd0);
        chk({tag, "_len"},        40'(bus.len_o),         40'd0);
    endtask

    // Monitor: every output handshake pops its expected value.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.hdr_valid_o && bus.hdr_ready_i) begin
                    if (hdr_q.size() == 0) fail_now("unexpected_hdr");
                    else chk("hdr", 40'({bus.opcode_o, bus.len_o}), 40'(hdr_q.pop_front()));
                end
                if (bus.op_tvalid_o && bus.op_tready_i) begin
                    if (op_q.size() == 0) fail_now("unexpected_op");
                    else chk("op", 40'({bus.op_tlast_o, bus.op_tdata_o}), 40'(op_q.pop_front()));
                end
                if (bus.echo_tvalid_o && bus.echo_tready_i) begin
                    if (echo_q.size() == 0) fail_now("unexpected_echo");
                    else chk("echo", 40'(bus.echo_tdata_o), 40'(echo_q.pop_front()));
                end
                if (bus.err_o) begin
                    if (err_pending == 0) fail_now("unexpected_err");
                    else begin
                        err_pending--;
                        n_cmp++;
                    end
                end
            end
        end
    end

    initial begin
        int t;
        n_cmp = 0;
        n_bad = 0;
        err_pending = 0;
        rst_n = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.hdr_ready_i   = 1'b1;
        bus.op_tready_i   = 1'b1;
        bus.echo_tready_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Echo packet
        hdr_q.push_back({8'hEC, 16'd6});
        echo_q.push_back(8'h41);
        echo_q.push_back(8'h42);
        pkt = {8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        send_pkt(pkt);
        repeat (4) @(negedge clk);
        chk("idle_tready_after_echo", 40'(bus.s_axis_tready), 40'd1);
        @(posedge clk); #1;

        // Add packet
        hdr_q.push_back({8'h10, 16'd12});
        op_q.push_back({1'b0, 32'h0000_0001});
        op_q.push_back({1'b1, 32'hFFFF_FFFF});
        pkt = {8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_pkt(pkt);

        // Same add packet, each word stalled 10 cycles
        hdr_q.push_back({8'h10, 16'd12});
        op_q.push_back({1'b0, 32'h0000_0001});
        op_q.push_back({1'b1, 32'hFFFF_FFFF});
        bus.op_tready_i = 1'b0;
        fork
            send_pkt(pkt);
            begin
                for (int w = 0; w < 2; w++) begin
                    t = 0;
                    @(negedge clk);
                    while (!bus.op_tvalid_o && t < 300) begin
                        t++;
                        @(negedge clk);
                    end
                    if (!bus.op_tvalid_o) fail_now("bp_word_timeout");
                    repeat (10) @(negedge clk);
                    if (w == 0) chk("bp_stall_tready", 40'(bus.s_axis_tready), 40'd0);
                    @(posedge clk); #1;
                    bus.op_tready_i = 1'b1;
                    @(posedge clk); #1;
                    bus.op_tready_i = 1'b0;
                end
            end
        join
        bus.op_tready_i = 1'b1;

        // Mul with len 7: payload 3 is not a word multiple, drained
        err_pending++;
        pkt = {8'h11, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(pkt);
        hdr_q.push_back({8'hEC, 16'd5});
        echo_q.push_back(8'h33);
        pkt = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
        send_pkt(pkt);

        // Unknown opcode drains one byte, short length drains none
        err_pending++;
        pkt = {8'h55, 8'h00, 8'h05, 8'h00, 8'h99};
        send_pkt(pkt);
        err_pending++;
        pkt = {8'hEC, 8'h00, 8'h02, 8'h00};
        send_pkt(pkt);
        hdr_q.push_back({8'hEC, 16'd4});
        pkt = {8'hEC, 8'h00, 8'h04, 8'h00};
        send_pkt(pkt);
        hdr_q.push_back({8'hEC, 16'd5});
        echo_q.push_back(8'h77);
        pkt = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
        send_pkt(pkt);
        hdr_q.push_back({8'h11, 16'd8});
        op_q.push_back({1'b1, 32'h0102_0304});
        pkt = {8'h11, 8'h00, 8'h08, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
        send_pkt(pkt);

        // Reset after the second operand byte
        hdr_q.push_back({8'h10, 16'd8});
        pkt = {8'h10, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02};
        send_pkt(pkt);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        hdr_q.push_back({8'h10, 16'd8});
        op_q.push_back({1'b1, 32'h1234_5678});
        pkt = {8'h10, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_pkt(pkt);

        t = 0;
        while ((hdr_q.size() + op_q.size() + echo_q.size() + err_pending) != 0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("hdr_left",  40'(hdr_q.size()),  40'd0);
        chk("op_left",   40'(op_q.size()),   40'd0);
        chk("echo_left", 40'(echo_q.size()), 40'd0);
        chk("err_left",  40'(err_pending),   40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_parser.md
# alu_cmd_parser

Byte-level command-packet parser at the receive end of the UART ALU. It accepts the AXI-stream byte output of the UART receiver, decodes packets (opcode, reserved, 16-bit length, payload), and emits a header handshake plus either 32-bit little-endian operand words for arithmetic opcodes or a raw byte stream for echo. It is the responder to the host-side sender that drives packets into the design's `rx_i` pin.

## Interface
- `DATA_WIDTH_P`, 8, byte width of the input stream.
- `OPERAND_WIDTH_P`, 32, operand word width; must be a multiple of `DATA_WIDTH_P`.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 8: received byte from the UART.
- `s_axis_tvalid` in 1: byte valid.
- `s_axis_tready` out 1: parser accepts byte.
- `hdr_valid_o` out 1: decoded header available.
- `hdr_ready_i` in 1: consumer takes header.
- `opcode_o` out 8: decoded opcode.
- `len_o` out 16: total packet length in bytes, header included.
- `op_tdata_o` out 32: assembled operand, little-endian.
- `op_tvalid_o` out 1: operand valid.
- `op_tready_i` in 1: operand accepted.
- `op_tlast_o` out 1: last operand of packet.
- `echo_tdata_o` out 8: echo payload byte.
- `echo_tvalid_o` out 1: echo byte valid.
- `echo_tready_i` in 1: echo byte accepted.
- `err_o` out 1: one-cycle pulse on malformed packet.

## Operation
- Opcodes:
  - 0xEC echo.
  - 0x10 add.
  - 0x11 mul.
  - 0x12 div.
  - Any other value is unknown.
- State machine:
  - OPCODE → RSVD → LEN_LO → LEN_HI: each state advances on an accepted byte.
  - After LEN_HI, go to HDR.
  - HDR holds `hdr_valid_o` until `hdr_ready_i`.
  - On the header handshake, go to PAYLOAD, or to OPCODE if `len_o`==4.
  - PAYLOAD returns to OPCODE after `len_o`−4 bytes.
  - DRAIN consumes the remaining payload bytes without output, then returns to OPCODE.
- Header checks, done in LEN_HI. Any failure pulses `err_o` and skips HDR:
  - `len` < 4: error, return to OPCODE with no payload consumed.
  - Unknown opcode: error, DRAIN `len`−4 bytes.
  - Arithmetic opcode with (`len`−4) not a multiple of 4, or (`len`−4) == 0: error, DRAIN.
- Payload handling:
  - Arithmetic: shift bytes in LSB-first. After the 4th byte, register the word onto `op_tdata_o`.
  - `op_tlast_o` is set on the final word of the packet.
  - Echo: each byte is registered onto `echo_tdata_o`.
- Payload byte counter is 16 bits and counts down from `len`−4. Reaching zero ends the packet; there is no wrap.

## Timing
- Reset values:
  - All valid outputs, `err_o`, and `s_axis_tready` are 0.
  - All data outputs are 0.
  - State is OPCODE.
  - Reset asserted mid-packet discards the partial packet immediately.
- `s_axis_tready`:
  - 1 in OPCODE, RSVD, LEN_LO, LEN_HI, and DRAIN.
  - 0 in HDR.
  - In PAYLOAD: `!op_tvalid_o || op_tready_i` for arithmetic, `!echo_tvalid_o || echo_tready_i` for echo.
- Latency:
  - `hdr_valid_o` rises 1 cycle after the LEN_HI byte is accepted.
  - `op_tvalid_o` rises 1 cycle after the 4th byte of a word is accepted.
  - `echo_tvalid_o` rises 1 cycle after the byte is accepted.
  - `err_o` pulses 1 cycle after the LEN_HI byte is accepted.
- Valid/data stability:
  - Valid, once high, holds with stable data until ready.
  - A simultaneous ready and new byte accept in the same cycle gives full throughput, 1 byte per cycle.
- `opcode_o` and `len_o` stay stable from HDR until the packet completes.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OP_ECHO`, `OP_ADD`, `OP_MUL`, `OP_DIV`.
  - Header length constant (4).
  - Parser state enum.
- One natural sub-module: `byte_to_word`, a 4-byte LSB-first accumulator with a valid/ready output register.

## Test plan
- **Echo packet.** Send EC 00 06 00 41 42 with ready held high. Required: header {0xEC, 6}, then echo bytes 0x41 and 0x42, then the parser is back in OPCODE.
- **Add packet.** Send 10 00 0C 00 01 00 00 00 FF FF FF FF. Required: `op_tdata_o`=0x00000001 (tlast 0), then 0xFFFFFFFF (tlast 1).
- **Backpressure.** Same add packet with `op_tready_i` low for 10 cycles on each word. Required: no byte lost, `s_axis_tready` low while the word is stalled, same two words produced.
- **Bad length.** Send 11 00 07 00 AA BB CC. Required: `err_o` pulse, no header or operand output, 3 bytes drained, then a following valid echo packet parses correctly.
- **Unknown opcode and short length.** Send 55 00 05 00 99. Required: error plus drain of 1 byte. Send EC 00 02 00. Required: error with no drain.
- **Reset mid-packet.** Pulse `rst_n` low after the 2nd operand byte. Required: all outputs 0, then a fresh add packet is parsed correctly.
